ad4003_sdo_capture: RTL

//  Downstream stage of ad4003_deserializer, in the adc_read_clk domain (80 MHz, MMCM-delayed).
//  Per frame: shifts in N_CH AD4003 SDO lines while reader_en_sync is high.

---
 rtl/ad4003_pkg.sv | 19 +
 rtl/ad4003_sdo_shifter.sv | 35 +++
 rtl/ad4003_sdo_capture.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ad4003_pkg.sv
`default_nettype none
// ============================================================================
// ad4003_pkg : shared constants and FSM encoding for the AD4003 SDO capture
// Rev 1.0
// ============================================================================
package ad4003_pkg;

  localparam int AD4003_DATA_W = 18;
  localparam int BITCNT_W      = 6;

  localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : ad4003_pkg
`default_nettype wire

// File: rtl/ad4003_sdo_shifter.sv
`default_nettype none
// ============================================================================
// ad4003_sdo_shifter : per-channel MSB-first shift register for one SDO line
// Rev 1.0
// ============================================================================
module ad4003_sdo_shifter
  import ad4003_pkg::*;
#(
  parameter int DATA_W = AD4003_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              shift_i,
  input  logic              sdo_i,
  output logic [DATA_W-1:0] sreg_o
);

  logic [DATA_W-1:0] sreg_q;

  // start clears stale bits so a short frame reads zero above its last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (start_i) begin
      sreg_q <= {{(DATA_W-1){1'b0}}, sdo_i};
    end else if (shift_i) begin
      sreg_q <= {sreg_q[DATA_W-2:0], sdo_i};
    end
  end

  assign sreg_o = sreg_q;

endmodule : ad4003_sdo_shifter
`default_nettype wire

// File: rtl/ad4003_sdo_capture.sv
`default_nettype none
// ============================================================================
// ad4003_sdo_capture : frames N_CH AD4003 SDO lines into sign-extended words
// Rev 1.0
// ============================================================================
module ad4003_sdo_capture
  import ad4003_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = AD4003_DATA_W,
  parameter int OUT_W  = 32
) (
  input  logic                  adc_read_clk,
  input  logic                  rst,
  input  logic                  reader_en_sync,
  input  logic [N_CH-1:0]       adc_sdo,
  input  logic                  clear_flags,
  input  logic                  sample_ready,
  output logic [N_CH*OUT_W-1:0] sample_data,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic                  bit_count_err,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

  state_e                state_q, state_d;
  logic                  start, shift, latch;
  logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     sreg [N_CH];
  logic [N_CH*OUT_W-1:0] word;
  logic [N_CH*OUT_W-1:0] sample_data_q, sample_data_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  bit_count_err_q, bit_count_err_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  len_bad;

  always_ff @(posedge adc_read_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (reader_en_sync)  state_d = ST_SHIFT;
      ST_SHIFT: if (!reader_en_sync) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    shift = 1'b0;
    latch = 1'b0;
    case (state_q)
      ST_IDLE:  start = reader_en_sync;
      ST_SHIFT: begin
        shift = reader_en_sync;
        latch = !reader_en_sync;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ad4003_sdo_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk     (adc_read_clk),
      .rst     (rst),
      .start_i (start),
      .shift_i (shift),
      .sdo_i   (adc_sdo[i]),
      .sreg_o  (sreg[i])
    );
    assign word[i*OUT_W +: OUT_W] = {{(OUT_W-DATA_W){sreg[i][DATA_W-1]}}, sreg[i]};
  end

  assign len_bad = (bit_cnt_q != BITCNT_W'(DATA_W));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (start)                               bit_cnt_d = BITCNT_W'(1);
    else if (shift && bit_cnt_q != BITCNT_MAX) bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
    else if (latch)                          bit_cnt_d = '0;

    sample_data_d  = latch ? word : sample_data_q;
    frame_err_d    = latch ? len_bad : frame_err_q;
    frame_cnt_d    = latch ? frame_cnt_q + 16'd1 : frame_cnt_q;
    // a latch always presents a fresh word, even if the old one was just taken
    sample_valid_d = latch | (sample_valid_q & ~sample_ready);
    // sets take priority over a coincident clear
    overrun_d       = (latch & sample_valid_q & ~sample_ready) | (overrun_q & ~clear_flags);
    bit_count_err_d = (latch & len_bad) | (bit_count_err_q & ~clear_flags);
  end

  always_ff @(posedge adc_read_clk) begin
    if (rst) begin
      bit_cnt_q       <= '0;
      sample_data_q   <= '0;
      sample_valid_q  <= 1'b0;
      frame_err_q     <= 1'b0;
      bit_count_err_q <= 1'b0;
      overrun_q       <= 1'b0;
      frame_cnt_q     <= '0;
    end else begin
      bit_cnt_q       <= bit_cnt_d;
      sample_data_q   <= sample_data_d;
      sample_valid_q  <= sample_valid_d;
      frame_err_q     <= frame_err_d;
      bit_count_err_q <= bit_count_err_d;
      overrun_q       <= overrun_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign sample_data   = sample_data_q;
  assign sample_valid  = sample_valid_q;
  assign frame_err     = frame_err_q;
  assign bit_count_err = bit_count_err_q;
  assign overrun       = overrun_q;
  assign frame_cnt     = frame_cnt_q;

endmodule : ad4003_sdo_capture
`default_nettype wire
